// File: rtl/oled_spi_master.sv
// SPI master for dual-controller OLED panels: runs the panel hardware reset, then
// shifts command/data words out in SPI mode 0, MSB first, from a valid/ready stream.
module oled_spi_master #(
  parameter int CLK_DIV         = 2,
  parameter int WORD_W          = 8,
  parameter int NUM_CS          = 2,
  parameter int RES_LOW_CYCLES  = 500000,
  parameter int RES_WAIT_CYCLES = 500000,
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [WORD_W-1:0] i_Data,
  input  logic              i_DC,
  input  logic [SEL_W-1:0]  i_CS_Sel,
  input  logic              i_Res_Req,
  output logic              o_Done,
  output logic              o_Err,
  output logic              o_Res,
  output logic [NUM_CS-1:0] o_CS_n,
  output logic              o_DC,
  output logic              o_SCK,
  output logic              o_MOSI
);

  localparam int MAX_A   = (CLK_DIV > WORD_W) ? CLK_DIV : WORD_W;
  localparam int MAX_B   = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RES_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RES_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sel_err;
  logic [WORD_W-1:0] shreg;

  // Out-of-range selects leave every chip select inactive.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  // Word shift register: remaining bits after the one currently on o_MOSI.
  always_ff @(posedge i_Clk) begin
    if (state == IDLE && i_Valid && !i_Res_Req) begin
      shreg <= i_Data << 1;
    end else if (state == SHIFT && cnt == DIV_LAST && o_SCK) begin
      shreg <= shreg << 1;
    end
  end

  always_ff @(posedge i_Clk) begin
    o_Done <= 1'b0;
    o_Err  <= 1'b0;
    if (i_Rst) begin
      state   <= RST_LOW;
      cnt     <= '0;
      bit_cnt <= '0;
      sel_err <= 1'b0;
      o_Res   <= 1'b0;
      o_CS_n  <= '1;
      o_SCK   <= 1'b0;
      o_MOSI  <= 1'b0;
      o_DC    <= 1'b0;
      o_Ready <= 1'b0;
    end else begin
      case (state)
        RST_LOW: begin
          if (cnt == LOW_LAST) begin
            state <= RST_WAIT;
            cnt   <= '0;
            o_Res <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            o_Ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (i_Res_Req) begin
            state   <= RST_LOW;
            cnt     <= '0;
            o_Res   <= 1'b0;
            o_Ready <= 1'b0;
          end else if (i_Valid) begin
            state   <= SETUP;
            cnt     <= '0;
            o_Ready <= 1'b0;
            o_CS_n  <= cs_decode(i_CS_Sel);
            o_DC    <= i_DC;
            o_MOSI  <= i_Data[WORD_W-1];
            sel_err <= (int'(i_CS_Sel) >= NUM_CS);
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
            o_SCK   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (o_SCK) begin
              // Falling edge: present the next bit; the last bit stays on the line.
              o_SCK <= 1'b0;
              if (bit_cnt != BIT_LAST) o_MOSI <= shreg[WORD_W-1];
            end else if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_SCK   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt == DIV_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            o_CS_n  <= '1;
            o_Ready <= 1'b1;
            o_Done  <= 1'b1;
            o_Err   <= sel_err;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RST_LOW;
          cnt   <= '0;
          o_Res <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_master.sv
// Bench for oled_spi_master: a two-select and a three-select build run in lockstep
// against a timeline-formula reference model, plus directed transfer/reset sequences.
module tb_oled_spi_master;

  localparam int CD = 2;
  localparam int WW = 8;
  localparam int RL = 4;
  localparam int RW = 6;
  localparam int T  = (2 * WW + 2) * CD;

  localparam int M_RST  = 0;
  localparam int M_IDLE = 1;
  localparam int M_XF   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       dc = 1'b0;
  logic       res_req = 1'b0;
  logic [7:0] data = 8'h00;
  logic       sel2 = 1'b0;
  logic [1:0] sel3 = 2'd0;

  logic       ready2, done2, err2, res2, dco2, sck2, mosi2;
  logic [1:0] cs2;
  logic       ready3, done3, err3, res3, dco3, sck3, mosi3;
  logic [2:0] cs3;

  oled_spi_master #(.CLK_DIV(CD), .WORD_W(WW), .NUM_CS(2),
                    .RES_LOW_CYCLES(RL), .RES_WAIT_CYCLES(RW)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .o_Ready(ready2), .i_Data(data),
    .i_DC(dc), .i_CS_Sel(sel2), .i_Res_Req(res_req), .o_Done(done2), .o_Err(err2),
    .o_Res(res2), .o_CS_n(cs2), .o_DC(dco2), .o_SCK(sck2), .o_MOSI(mosi2)
  );

  oled_spi_master #(.CLK_DIV(CD), .WORD_W(WW), .NUM_CS(3),
                    .RES_LOW_CYCLES(RL), .RES_WAIT_CYCLES(RW)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .o_Ready(ready3), .i_Data(data),
    .i_DC(dc), .i_CS_Sel(sel3), .i_Res_Req(res_req), .o_Done(done3), .o_Err(err3),
    .o_Res(res3), .o_CS_n(cs3), .o_DC(dco3), .o_SCK(sck3), .o_MOSI(mosi3)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus cycles elapsed in it; outputs follow from formulas.
  int         m_mode[2];
  int         m_t[2];
  int         m_sel[2];
  logic [7:0] m_data[2];
  logic       m_dc[2];
  logic       m_lmosi[2];
  logic       m_ldc[2];
  logic       m_done[2];
  logic       m_err[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_done[k] <= 1'b0;
      m_err[k]  <= 1'b0;
      if (rst) begin
        m_mode[k]  <= M_RST;
        m_t[k]     <= 0;
        m_lmosi[k] <= 1'b0;
        m_ldc[k]   <= 1'b0;
      end else if (m_mode[k] == M_RST) begin
        if (m_t[k] == RL + RW - 1) begin
          m_mode[k] <= M_IDLE;
          m_t[k]    <= 0;
        end else begin
          m_t[k] <= m_t[k] + 1;
        end
      end else if (m_mode[k] == M_IDLE) begin
        if (res_req) begin
          m_mode[k] <= M_RST;
          m_t[k]    <= 0;
        end else if (valid) begin
          m_mode[k] <= M_XF;
          m_t[k]    <= 0;
          m_data[k] <= data;
          m_dc[k]   <= dc;
          m_sel[k]  <= (k == 0) ? int'(sel2) : int'(sel3);
        end
      end else begin
        if (m_t[k] == T - 1) begin
          m_mode[k]  <= M_IDLE;
          m_t[k]     <= 0;
          m_done[k]  <= 1'b1;
          m_err[k]   <= (m_sel[k] >= ((k == 0) ? 2 : 3));
          m_lmosi[k] <= m_data[k][0];
          m_ldc[k]   <= m_dc[k];
        end else begin
          m_t[k] <= m_t[k] + 1;
        end
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cs_mask(input int ncs, input int sel, input bit active);
    int m;
    m = (1 << ncs) - 1;
    if (active && sel < ncs) m = m & ~(1 << sel);
    return m;
  endfunction

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      int ph, idx, e_sck;
      bit xf;
      xf  = (m_mode[k] == M_XF);
      ph  = m_t[k];
      idx = ph / (2 * CD);
      if (idx > WW - 1) idx = WW - 1;
      e_sck = (xf && ph >= CD && ph < CD + 2 * WW * CD && ((ph - CD) % (2 * CD)) < CD) ? 1 : 0;
      chk($sformatf("dut%0d o_Res", k), (k == 0) ? int'(res2) : int'(res3),
          (m_mode[k] == M_RST && ph < RL) ? 0 : 1);
      chk($sformatf("dut%0d o_Ready", k), (k == 0) ? int'(ready2) : int'(ready3),
          (m_mode[k] == M_IDLE) ? 1 : 0);
      chk($sformatf("dut%0d o_CS_n", k), (k == 0) ? int'(cs2) : int'(cs3),
          cs_mask((k == 0) ? 2 : 3, m_sel[k], xf));
      chk($sformatf("dut%0d o_SCK", k), (k == 0) ? int'(sck2) : int'(sck3), e_sck);
      chk($sformatf("dut%0d o_MOSI", k), (k == 0) ? int'(mosi2) : int'(mosi3),
          xf ? int'(m_data[k][WW-1-idx]) : int'(m_lmosi[k]));
      chk($sformatf("dut%0d o_DC", k), (k == 0) ? int'(dco2) : int'(dco3),
          xf ? int'(m_dc[k]) : int'(m_ldc[k]));
      chk($sformatf("dut%0d o_Done", k), (k == 0) ? int'(done2) : int'(done3), int'(m_done[k]));
      chk($sformatf("dut%0d o_Err", k), (k == 0) ? int'(err2) : int'(err3), int'(m_err[k]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !(ready2 && ready3); i++) step();
    chk("wait for o_Ready", int'(ready2 && ready3), 1);
  endtask

  // Count o_Res low/high cycles of a reset sequence starting at the current cycle.
  task automatic measure_reset(input string tag);
    int lowc, highc, saw_done;
    lowc = 0; highc = 0; saw_done = 0;
    for (int i = 0; i < 40 && !ready2; i++) begin
      if (!res2) lowc++; else highc++;
      if (done2 || done3) saw_done = 1;
      step();
    end
    chk($sformatf("%s res low cycles", tag), lowc, RL);
    chk($sformatf("%s res wait cycles", tag), highc, RW);
    chk($sformatf("%s no done", tag), saw_done, 0);
    chk($sformatf("%s ready after", tag), int'(ready2), 1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       dcv;
    logic       s2;
    logic [1:0] s3;
    logic [1:0] cs2e;
    logic [2:0] cs3e;
    logic       err3e;
  } vec_t;

  task automatic run_vec(input vec_t v, input int n);
    logic [7:0] b2, b3;
    logic       p2, p3;
    int done_t2, done_t3, nb2, nb3, cs_mid2, cs_mid3, dc_mid, err_at, cs_at;
    wait_ready();
    data = v.d; dc = v.dcv; sel2 = v.s2; sel3 = v.s3; valid = 1'b1;
    step();
    valid = 1'b0; data = 8'($urandom); dc = ~v.dcv; sel2 = ~v.s2; sel3 = 2'($urandom);
    b2 = '0; b3 = '0; p2 = 1'b0; p3 = 1'b0; nb2 = 0; nb3 = 0;
    done_t2 = -1; done_t3 = -1; cs_mid2 = -1; cs_mid3 = -1; dc_mid = -1; err_at = -1; cs_at = -1;
    for (int t = 0; t <= T; t++) begin
      if (sck2 && !p2) begin b2 = {b2[6:0], mosi2}; nb2++; end
      if (sck3 && !p3) begin b3 = {b3[6:0], mosi3}; nb3++; end
      p2 = sck2; p3 = sck3;
      if (t == 10) begin cs_mid2 = int'(cs2); cs_mid3 = int'(cs3); dc_mid = int'(dco2); end
      if (done2 && done_t2 < 0) done_t2 = t;
      if (done3 && done_t3 < 0) begin done_t3 = t; err_at = int'(err3); cs_at = int'(cs3); end
      if (t < T) step();
    end
    chk($sformatf("vec%0d dut0 bits", n), int'(b2), int'(v.d));
    chk($sformatf("vec%0d dut1 bits", n), int'(b3), int'(v.d));
    chk($sformatf("vec%0d rising edges", n), nb2 + nb3, 2 * WW);
    chk($sformatf("vec%0d dut0 cs", n), cs_mid2, int'(v.cs2e));
    chk($sformatf("vec%0d dut1 cs", n), cs_mid3, int'(v.cs3e));
    chk($sformatf("vec%0d dc", n), dc_mid, int'(v.dcv));
    chk($sformatf("vec%0d dut0 done latency", n), done_t2, T);
    chk($sformatf("vec%0d dut1 done latency", n), done_t3, T);
    chk($sformatf("vec%0d dut1 err", n), err_at, int'(v.err3e));
    chk($sformatf("vec%0d dut1 cs on done", n), cs_at, 7);
  endtask

  initial begin
    vec_t vecs[5];
    int d1, d2, res_low_seen, dt;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 2'd0, 2'b10, 3'b110, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 2'd2, 2'b01, 3'b011, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 2'd3, 2'b10, 3'b111, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 2'd1, 2'b01, 3'b101, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 2'd2, 2'b10, 3'b011, 1'b0};

    // Power-up reset sequence.
    step();
    step();
    chk("reset o_Res", int'(res2), 0);
    chk("reset o_Ready", int'(ready2), 0);
    chk("reset o_CS_n", int'(cs2), 3);
    chk("reset o_SCK", int'(sck2), 0);
    rst = 1'b0;
    measure_reset("powerup");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Back-to-back words with i_Valid held.
    wait_ready();
    data = 8'hFF; dc = 1'b1; sel2 = 1'b1; sel3 = 2'd1; valid = 1'b1;
    step();
    data = 8'h00; dc = 1'b0; sel2 = 1'b0; sel3 = 2'd0;
    d1 = -1; d2 = -1;
    for (int t = 0; t <= T + 1 + T; t++) begin
      if (t == 10) begin
        chk("b2b word1 cs", int'(cs2), 2'b01);
        chk("b2b word1 dc", int'(dco2), 1);
      end
      if (t == T + 11) begin
        chk("b2b word2 cs", int'(cs2), 2'b10);
        chk("b2b word2 dc", int'(dco2), 0);
      end
      if (done2) begin
        if (d1 < 0) begin d1 = t; chk("b2b cs on done", int'(cs2), 3); end
        else if (d2 < 0) d2 = t;
      end
      if (t == T + 1) valid = 1'b0;
      if (t < 2 * T + 1) step();
    end
    chk("b2b first done", d1, T);
    chk("b2b second done", d2, 2 * T + 1);

    // Reset request wins over a simultaneous valid.
    wait_ready();
    data = 8'h55; valid = 1'b1; res_req = 1'b1;
    step();
    valid = 1'b0; res_req = 1'b0;
    chk("resreq ready drops", int'(ready2), 0);
    measure_reset("resreq");

    // Reset request during a transfer is ignored.
    wait_ready();
    data = 8'h81; dc = 1'b1; sel2 = 1'b1; sel3 = 2'd1; valid = 1'b1;
    step();
    valid = 1'b0;
    res_low_seen = 0; dt = -1;
    for (int t = 0; t <= T; t++) begin
      res_req = (t == 10);
      if (!res2) res_low_seen = 1;
      if (done2 && dt < 0) dt = t;
      if (t < T) step();
    end
    res_req = 1'b0;
    chk("midreq res stays high", res_low_seen, 0);
    chk("midreq done latency", dt, T);

    // i_Rst during bit 4 aborts the transfer.
    wait_ready();
    data = 8'hC3; dc = 1'b0; sel2 = 1'b0; sel3 = 2'd0; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int t = 0; t < CD + 4 * 2 * CD; t++) step();
    chk("abort sck high at bit4", int'(sck2), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort cs", int'(cs2), 3);
    chk("abort sck", int'(sck2), 0);
    chk("abort res", int'(res2), 0);
    chk("abort done", int'(done2), 0);
    measure_reset("abort");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      valid   = 1'($urandom_range(0, 1));
      data    = 8'($urandom);
      dc      = 1'($urandom);
      sel2    = 1'($urandom);
      sel3    = 2'($urandom);
      res_req = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; valid = 1'b0; res_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
